prio_code_decoder: RTL and testbench

//   Receive-side counterpart of the 8:3 priority encoder. Takes the binary index

---
 rtl/prio_code_decoder.sv | 168 ++++++++++++++++
 tb/tb_prio_code_decoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_code_decoder.sv
`default_nettype none
// ============================================================================
// Module   : prio_code_decoder
// Purpose  : Receive-side companion of the 8:3 priority encoder. Buffers
//            encoded indices in a 2-entry valid/ready skid buffer and
//            regenerates a one-hot line vector for the head entry. Also
//            flags input-side handshake violations in a sticky error bit.
// Options  : PRIO_DEC_SEEN_EN - adds seen_clr / seen_mask, a sticky record
//            of every one-hot line delivered downstream.
// Revision : 1.0 - initial release
// ============================================================================
module prio_code_decoder #(
  parameter int CODE_W = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CODE_W-1:0]          in_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CODE_W-1:0]          out_code,
  output logic [(1 << CODE_W)-1:0]   out_onehot,
`ifdef PRIO_DEC_SEEN_EN
  input  logic                       seen_clr,
  output logic [(1 << CODE_W)-1:0]   seen_mask,
`endif
  input  logic                       err_clr,
  output logic                       proto_err
);

  localparam int OUT_W = 1 << CODE_W;

  // Occupancy of the skid buffer: number of entries currently held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // r_head is the entry presented downstream; r_tail is the skid slot.
  logic [CODE_W-1:0]   r_head;
  logic [CODE_W-1:0]   r_tail;
  logic [CODE_W-1:0]   w_head_nxt;
  logic [CODE_W-1:0]   w_tail_nxt;

  logic                w_push;
  logic                w_pop;
  logic [OUT_W-1:0]    w_onehot;

  // Stall tracking for the input handshake checker.
  logic                r_stall;
  logic [CODE_W-1:0]   r_stall_code;
  logic                r_proto_err;
  logic                w_violation;

  // Handshake qualifiers are derived from registered state only, so there is
  // no combinational path from out_ready to in_ready or from in_* to out_*.
  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_code   = r_head;
  assign w_onehot   = OUT_W'(1) << r_head;
  assign out_onehot = out_valid ? w_onehot : '0;

  // Next occupancy and next contents of the two buffer slots.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_head_nxt  = in_code;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_push && !w_pop) begin
          w_tail_nxt  = in_code;
          w_state_nxt = ST_TWO;
        end else if (w_pop && !w_push) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_push && w_pop) begin
          // Head leaves and the new code takes its place in the same cycle.
          w_head_nxt  = in_code;
          w_state_nxt = ST_ONE;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (w_pop) begin
          w_head_nxt  = r_tail;
          w_state_nxt = ST_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Occupancy state and buffer slots; reset discards anything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  // A stalled offer must be held unchanged until it is accepted; dropping
  // valid or altering the code in the following cycle is a violation.
  assign w_violation = r_stall & (~in_valid | (in_code != r_stall_code));

  // Remember whether this cycle was a stall, and what code was on offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall      <= 1'b0;
      r_stall_code <= '0;
    end else begin
      r_stall      <= in_valid & ~in_ready;
      r_stall_code <= in_code;
    end
  end

  // Sticky error flag; a fresh violation wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (w_violation) begin
      r_proto_err <= 1'b1;
    end else if (err_clr) begin
      r_proto_err <= 1'b0;
    end
  end

  assign proto_err = r_proto_err;

`ifdef PRIO_DEC_SEEN_EN
  logic [OUT_W-1:0] r_seen_mask;

  // Accumulate every line delivered; a clear coinciding with a pop keeps
  // only the line popped in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_mask <= '0;
    end else if (seen_clr) begin
      r_seen_mask <= w_pop ? w_onehot : '0;
    end else if (w_pop) begin
      r_seen_mask <= r_seen_mask | w_onehot;
    end
  end

  assign seen_mask = r_seen_mask;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prio_code_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_code_decoder
// Purpose  : Self-checking bench for prio_code_decoder. A negedge monitor
//            keeps a queue of accepted codes and compares every pop, plus a
//            small reference for occupancy and the sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_code_decoder;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 1 << CODE_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic [OUT_W-1:0]  out_onehot;
  logic              err_clr;
  logic              proto_err;
`ifdef PRIO_DEC_SEEN_EN
  logic              seen_clr;
  logic [OUT_W-1:0]  seen_mask;
  logic [OUT_W-1:0]  m_seen;
`endif

  int n_checks;
  int n_pass;

  // Reference state kept by the monitor.
  logic [CODE_W-1:0] q_exp[$];
  logic              m_err;
  logic              m_stall;
  logic [CODE_W-1:0] m_code;

  prio_code_decoder #(.CODE_W(CODE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_onehot (out_onehot),
`ifdef PRIO_DEC_SEEN_EN
    .seen_clr   (seen_clr),
    .seen_mask  (seen_mask),
`endif
    .err_clr    (err_clr),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q_exp.delete();
    m_err   = 1'b0;
    m_stall = 1'b0;
    m_code  = '0;
`ifdef PRIO_DEC_SEEN_EN
    m_seen  = '0;
`endif
  endtask

  // Monitor: inputs are stable between posedge+1 and the next posedge, so
  // the negedge sees exactly what the upcoming edge will act on.
  always @(negedge clk) begin
    logic [CODE_W-1:0] e;
    logic [OUT_W-1:0]  eoh;
    logic              viol;
    if (rst_n) begin
      check("in_ready",  in_ready,  q_exp.size() < 2);
      check("out_valid", out_valid, q_exp.size() != 0);
      check("proto_err", proto_err, m_err);
`ifdef PRIO_DEC_SEEN_EN
      check("seen_mask", seen_mask, m_seen);
`endif
      if (q_exp.size() == 0) check("onehot_idle", out_onehot, 0);
      if (out_valid && out_ready && q_exp.size() > 0) begin
        e   = q_exp.pop_front();
        eoh = OUT_W'(1) << e;
        check("pop_code",   out_code,   e);
        check("pop_onehot", out_onehot, eoh);
`ifdef PRIO_DEC_SEEN_EN
        m_seen = seen_clr ? eoh : (m_seen | eoh);
      end else if (seen_clr) begin
        m_seen = '0;
`endif
      end
      if (in_valid && in_ready) q_exp.push_back(in_code);
      viol    = m_stall && (!in_valid || in_code != m_code);
      m_err   = viol || (m_err && !err_clr);
      m_stall = in_valid && !in_ready;
      m_code  = in_code;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
`ifdef PRIO_DEC_SEEN_EN
    seen_clr  = 1'b0;
`endif
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset values.
    check("rst_out_valid",  out_valid,  0);
    check("rst_in_ready",   in_ready,   1);
    check("rst_out_code",   out_code,   0);
    check("rst_out_onehot", out_onehot, 0);
    check("rst_proto_err",  proto_err,  0);

    // Single code, one cycle latency, immediate pop.
    in_valid = 1'b1; in_code = 3'd5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_valid",  out_valid,  1);
    check("t1_onehot", out_onehot, 8'h20);
    tick();
    check("t1_empty_valid",  out_valid,  0);
    check("t1_empty_onehot", out_onehot, 0);

    // Fill with back-pressure, hold a third code, then release.
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'd7;
    tick();
    in_code = 3'd0;
    tick();
    check("t2_full_ready", in_ready, 0);
    in_code = 3'd3;
    tick();
    tick();
    out_ready = 1'b1;
    check("t2_head7", out_onehot, 8'h80);
    tick();
    check("t2_head0", out_onehot, 8'h01);
    tick();
    in_valid = 1'b0;
    check("t2_head3", out_onehot, 8'h08);
    tick();
    check("t2_drained", out_valid, 0);

    // Full-rate stream 0..7.
    for (int i = 0; i < OUT_W; i++) begin
      in_valid = 1'b1; in_code = CODE_W'(i);
      tick();
      check("t3_stream", out_onehot, OUT_W'(1) << i);
    end
    in_valid = 1'b0;
    tick();

    // Protocol violation while stalled, clear coinciding with a new
    // violation, then a clean clear.
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'd1;
    tick();
    in_code = 3'd2;
    tick();
    in_code = 3'd3;
    tick();
    check("t4_no_err_yet", proto_err, 0);
    in_code = 3'd4;
    tick();
    check("t4_err_set", proto_err, 1);
    in_valid = 1'b0; err_clr = 1'b1;
    tick();
    check("t4_err_clr_vs_viol", proto_err, 1);
    tick();
    err_clr = 1'b0;
    check("t4_err_cleared", proto_err, 0);
    out_ready = 1'b1;
    tick();
    tick();
    check("t4_drained", out_valid, 0);

    // Asynchronous reset with two entries buffered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'd5;
    tick();
    in_code = 3'd6;
    tick();
    in_valid = 1'b0;
    check("t5_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid",  out_valid,  0);
    check("t5_rst_ready",  in_ready,   1);
    check("t5_rst_onehot", out_onehot, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_post_valid", out_valid, 0);

`ifdef PRIO_DEC_SEEN_EN
    // Seen mask accumulation and clear-with-pop.
    out_ready = 1'b1;
    in_valid = 1'b1; in_code = 3'd1;
    tick();
    in_code = 3'd6;
    tick();
    in_valid = 1'b0;
    tick();
    check("t6_seen_42", seen_mask, 8'h42);
    in_valid = 1'b1; in_code = 3'd2;
    tick();
    in_valid = 1'b0; seen_clr = 1'b1;
    tick();
    seen_clr = 1'b0;
    check("t6_seen_04", seen_mask, 8'h04);
`endif

    // Random traffic, including occasional protocol violations and clears.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_code   = CODE_W'($urandom_range(0, OUT_W - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 7) == 0);
`ifdef PRIO_DEC_SEEN_EN
      seen_clr  = ($urandom_range(0, 9) == 0);
`endif
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b1;
`ifdef PRIO_DEC_SEEN_EN
    seen_clr  = 1'b0;
`endif
    tick();
    tick();
    tick();
    err_clr = 1'b0;
    tick();
    check("final_sb_empty", q_exp.size(), 0);
    check("final_valid",    out_valid,    0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
